mem_to_fifo: RTL and testbench

Replay read engine of the pcap replay micro-engine, directly downstream of the SRAM write path. For each enabled queue it reads the queue's memory region from its low address up to its high address, repeating the region a programmed number of times. Requests from eligible queues are round-robin arbitrated onto the single SRAM read port. Returned data is reassembled into FIFO words and written, tagged with its queue id, into the per-queue output FIFOs that feed the AXI-Stream packet emitters.

---
 rtl/mem_to_fifo_pkg.sv | 32 +++
 rtl/mem_to_fifo_rd_tag_fifo.sv | 61 ++++++
 rtl/mem_to_fifo.sv | 210 +++++++++++++++++++++
 tb/tb_mem_to_fifo.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_to_fifo_pkg.sv
// mem_to_fifo shared types and helpers.
// Queue FSM states, beat constants, round-robin pick.
package mem_to_fifo_pkg;

   typedef enum logic [1:0] {
      Q_IDLE = 2'd0,
      Q_RUN  = 2'd1,
      Q_DONE = 2'd2
   } q_state_e;

   localparam int BEATS_PER_WORD = 2;
   localparam int RR_MAX = 32;

   // First set bit of elig searching upward from last+1, wrapping at n.
   // Returns -1 when nothing is eligible.
   function automatic int rr_pick(
      input logic [RR_MAX-1:0] elig,
      input int                n,
      input int                last
   );
      int idx;
      int pick;
      pick = -1;
      for (int k = 1; k <= RR_MAX; k++) begin
         idx = (last + k) % n;
         if (k <= n && pick < 0 && elig[idx[4:0]])
            pick = idx;
      end
      return pick;
   endfunction

endpackage

// File: rtl/mem_to_fifo_rd_tag_fifo.sv
// Read tag FIFO: queue id of every read in flight.
// Push ignored when full, pop ignored when empty.
module rd_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clr,
   input  logic                   push,
   input  logic [W-1:0]           din,
   input  logic                   pop,
   output logic [W-1:0]           dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Storage, pointers and registered occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            mem[i] <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop)
            rd_ptr <= rd_ptr + PW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/mem_to_fifo.sv
// Replay read engine: per-queue region walkers,
// round-robin SRAM read issue, beat reassembly.
module mem_to_fifo
   import mem_to_fifo_pkg::*;
#(
   parameter int NUM_QUEUES       = 4,
   parameter int NUM_QUEUES_BITS  = 2,
   parameter int FIFO_DATA_WIDTH  = 144,
   parameter int MEM_ADDR_WIDTH   = 19,
   parameter int MEM_DATA_WIDTH   = 36,
   parameter int REPLAY_CNT_WIDTH = 16,
   parameter int MAX_OUTSTANDING  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     sw_rst,
   input  logic                     cal_done,
   output logic                     mem_r_n,
   output logic [MEM_ADDR_WIDTH-1:0] mem_ad_rd,
   input  logic                     mem_rd_full,
   input  logic                     mem_qr_valid,
   input  logic [MEM_DATA_WIDTH-1:0] mem_qrl,
   input  logic [MEM_DATA_WIDTH-1:0] mem_qrh,
   output logic                     fifo_wr_en,
   output logic [FIFO_DATA_WIDTH-1:0] fifo_data,
   output logic [NUM_QUEUES_BITS-1:0] fifo_qid,
   input  logic [NUM_QUEUES-1:0]    fifo_prog_full,
   input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_low,
   input  logic [NUM_QUEUES*MEM_ADDR_WIDTH-1:0] q_addr_high,
   input  logic [NUM_QUEUES*REPLAY_CNT_WIDTH-1:0] q_replay_cnt,
   input  logic [NUM_QUEUES-1:0]    q_enable,
   output logic [NUM_QUEUES-1:0]    q_done
);

   localparam int AW = MEM_ADDR_WIDTH;
   localparam int RW = REPLAY_CNT_WIDTH;
   localparam int QB = NUM_QUEUES_BITS;
   localparam int HW = 2 * MEM_DATA_WIDTH;
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic LAST_BEAT = 1'(BEATS_PER_WORD - 1);

   q_state_e              st   [NUM_QUEUES];
   logic [AW-1:0]         ptr  [NUM_QUEUES];
   logic [RW-1:0]         pass [NUM_QUEUES];
   logic [NUM_QUEUES-1:0] en_q;
   logic [NUM_QUEUES-1:0] elig;
   logic [QB-1:0]         rr_last;
   logic [QB-1:0]         win_q;
   int                    pick;
   logic                  grant;

   logic                  tag_full;
   logic                  tag_empty;
   logic                  tag_pop;
   logic [QB-1:0]         tag_head;
   logic [CW-1:0]         tag_cnt_unused;

   logic                  beat;
   logic [HW-1:0]         lo_half;

   // Queues competing for the read port this cycle.
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_QUEUES; i++)
         elig[i] = (st[i] == Q_RUN) && !fifo_prog_full[i];
   end

   // Round-robin winner, searched from the queue after the last grant.
   always_comb begin
      pick  = rr_pick(RR_MAX'(elig), NUM_QUEUES, int'(rr_last));
      win_q = QB'(pick);
   end

   assign grant = cal_done && !mem_rd_full && !tag_full && (|elig);

   // Per-queue region walker FSMs and done flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q   <= '0;
         q_done <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            st[i]   <= Q_IDLE;
            ptr[i]  <= '0;
            pass[i] <= '0;
         end
      end else if (sw_rst) begin
         en_q   <= '0;
         q_done <= '0;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            st[i]   <= Q_IDLE;
            ptr[i]  <= '0;
            pass[i] <= '0;
         end
      end else begin
         en_q <= q_enable;
         for (int i = 0; i < NUM_QUEUES; i++) begin
            if (!q_enable[i]) begin
               st[i]     <= Q_IDLE;
               ptr[i]    <= q_addr_low[i*AW +: AW];
               pass[i]   <= q_replay_cnt[i*RW +: RW];
               q_done[i] <= 1'b0;
            end else begin
               unique case (st[i])
                  Q_IDLE: begin
                     if (!en_q[i]) begin
                        ptr[i]  <= q_addr_low[i*AW +: AW];
                        pass[i] <= q_replay_cnt[i*RW +: RW];
                        if (q_addr_low[i*AW +: AW] ==
                            q_addr_high[i*AW +: AW]) begin
                           st[i]     <= Q_DONE;
                           q_done[i] <= 1'b1;
                        end else begin
                           st[i] <= Q_RUN;
                        end
                     end
                  end
                  Q_RUN: begin
                     if (grant && win_q == QB'(i)) begin
                        if (ptr[i] ==
                            q_addr_high[i*AW +: AW] - AW'(1)) begin
                           ptr[i] <= q_addr_low[i*AW +: AW];
                           // pass 0 means replay forever
                           if (pass[i] != '0) begin
                              pass[i] <= pass[i] - RW'(1);
                              if (pass[i] == RW'(1)) begin
                                 st[i]     <= Q_DONE;
                                 q_done[i] <= 1'b1;
                              end
                           end
                        end else begin
                           ptr[i] <= ptr[i] + AW'(1);
                        end
                     end
                  end
                  Q_DONE: ;
                  default: st[i] <= Q_IDLE;
               endcase
            end
         end
      end
   end

   // Registered read strobe/address and round-robin history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_r_n   <= 1'b1;
         mem_ad_rd <= '0;
         rr_last   <= '0;
      end else if (sw_rst) begin
         mem_r_n   <= 1'b1;
         mem_ad_rd <= '0;
         rr_last   <= '0;
      end else begin
         mem_r_n <= !grant;
         if (grant) begin
            mem_ad_rd <= ptr[win_q];
            rr_last   <= win_q;
         end
      end
   end

   rd_tag_fifo #(
      .W     (QB),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (sw_rst),
      .push  (grant),
      .din   (win_q),
      .pop   (tag_pop),
      .dout  (tag_head),
      .full  (tag_full),
      .empty (tag_empty),
      .count (tag_cnt_unused)
   );

   assign tag_pop = mem_qr_valid && !tag_empty && (beat == LAST_BEAT);

   // Pair read beats into words; beats with no tag are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat       <= 1'b0;
         lo_half    <= '0;
         fifo_wr_en <= 1'b0;
         fifo_data  <= '0;
         fifo_qid   <= '0;
      end else if (sw_rst) begin
         beat       <= 1'b0;
         lo_half    <= '0;
         fifo_wr_en <= 1'b0;
         fifo_data  <= '0;
         fifo_qid   <= '0;
      end else begin
         fifo_wr_en <= 1'b0;
         if (mem_qr_valid && !tag_empty) begin
            if (beat != LAST_BEAT) begin
               lo_half <= {mem_qrh, mem_qrl};
               beat    <= 1'b1;
            end else begin
               fifo_data  <= {mem_qrh, mem_qrl, lo_half};
               fifo_qid   <= tag_head;
               fifo_wr_en <= 1'b1;
               beat       <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_to_fifo.sv
// mem_to_fifo bench: SRAM responder model, word scoreboard,
// table of region runs plus multi-cycle corner sequences.
module tb_mem_to_fifo;

   localparam int NQ = 4;
   localparam int QB = 2;
   localparam int AW = 19;
   localparam int DW = 36;
   localparam int RW = 16;
   localparam int FW = 144;

   logic clk = 1'b0;
   logic rst_n, sw_rst, cal_done;
   logic mem_r_n, mem_rd_full, mem_qr_valid;
   logic [AW-1:0] mem_ad_rd;
   logic [DW-1:0] mem_qrl, mem_qrh;
   logic fifo_wr_en;
   logic [FW-1:0] fifo_data;
   logic [QB-1:0] fifo_qid;
   logic [NQ-1:0] fifo_prog_full, q_enable, q_done;
   logic [NQ*AW-1:0] q_addr_low, q_addr_high;
   logic [NQ*RW-1:0] q_replay_cnt;

   always #5 clk = ~clk;

   mem_to_fifo dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sw_rst         (sw_rst),
      .cal_done       (cal_done),
      .mem_r_n        (mem_r_n),
      .mem_ad_rd      (mem_ad_rd),
      .mem_rd_full    (mem_rd_full),
      .mem_qr_valid   (mem_qr_valid),
      .mem_qrl        (mem_qrl),
      .mem_qrh        (mem_qrh),
      .fifo_wr_en     (fifo_wr_en),
      .fifo_data      (fifo_data),
      .fifo_qid       (fifo_qid),
      .fifo_prog_full (fifo_prog_full),
      .q_addr_low     (q_addr_low),
      .q_addr_high    (q_addr_high),
      .q_replay_cnt   (q_replay_cnt),
      .q_enable       (q_enable),
      .q_done         (q_done)
   );

   typedef struct {
      logic [QB-1:0] qid;
      logic [FW-1:0] data;
   } exp_t;

   typedef struct {
      logic [AW-1:0] a;
      int            t;
   } rsp_t;

   typedef struct {
      int            q;
      logic [AW-1:0] lo;
      logic [AW-1:0] hi;
      logic [RW-1:0] cnt;
      int            nrd;
   } vec_t;

   exp_t          sb[$];
   rsp_t          rq[$];
   logic [AW-1:0] req_log[$];
   int            req_cyc[$];
   int            wr_cyc[$];
   int            cyc = 0;
   int            n_chk = 0;
   int            n_fail = 0;
   bit            half = 1'b0;
   bit            stray = 1'b0;
   bit            mem_hold = 1'b0;
   logic [AW-1:0] cur_a;

   task automatic chk(input string nm, input logic [FW-1:0] act,
                      input logic [FW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [2*DW-1:0] beat_of(input logic [AW-1:0] a,
                                               input bit b);
      logic [DW-1:0] l;
      l = {(b ? 17'h15A5A : 17'h0C3C3), a};
      return {~l, l};
   endfunction

   function automatic logic [FW-1:0] word_of(input logic [AW-1:0] a);
      return {beat_of(a, 1'b1), beat_of(a, 1'b0)};
   endfunction

   function automatic int qid_of(input logic [AW-1:0] a);
      for (int q = 0; q < NQ; q++)
         if (a >= q_addr_low[q*AW +: AW] && a < q_addr_high[q*AW +: AW])
            return q;
      return 0;
   endfunction

   // Monitor, scoreboard and SRAM read responder (2 beats/request).
   initial begin
      exp_t e;
      mem_qr_valid = 1'b0;
      mem_qrl = '0;
      mem_qrh = '0;
      forever begin
         @(negedge clk);
         cyc++;
         mem_qr_valid = 1'b0;
         if (rst_n) begin
            if (mem_r_n === 1'b0) begin
               req_log.push_back(mem_ad_rd);
               req_cyc.push_back(cyc);
               sb.push_back('{QB'(qid_of(mem_ad_rd)), word_of(mem_ad_rd)});
               rq.push_back('{mem_ad_rd, cyc + 2});
            end
            if (fifo_wr_en === 1'b1) begin
               wr_cyc.push_back(cyc);
               if (sb.size() == 0) begin
                  chk("unexpected_word", FW'(1), FW'(0));
               end else begin
                  e = sb.pop_front();
                  chk("word_data", fifo_data, e.data);
                  chk("word_qid", FW'(fifo_qid), FW'(e.qid));
               end
            end
            if (half) begin
               {mem_qrh, mem_qrl} = beat_of(cur_a, 1'b1);
               mem_qr_valid = 1'b1;
               half = 1'b0;
            end else if (stray) begin
               {mem_qrh, mem_qrl} = {72{1'b1}};
               mem_qr_valid = 1'b1;
               stray = 1'b0;
            end else if (!mem_hold && rq.size() > 0 && rq[0].t <= cyc) begin
               cur_a = rq.pop_front().a;
               {mem_qrh, mem_qrl} = beat_of(cur_a, 1'b0);
               mem_qr_valid = 1'b1;
               half = 1'b1;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic cfg(input int q, input logic [AW-1:0] lo,
                      input logic [AW-1:0] hi, input logic [RW-1:0] cnt);
      q_addr_low[q*AW +: AW]   = lo;
      q_addr_high[q*AW +: AW]  = hi;
      q_replay_cnt[q*RW +: RW] = cnt;
   endtask

   task automatic wait_done(input string nm, input int q, input int bound);
      int k = 0;
      while (q_done[q] !== 1'b1 && k < bound) begin
         tick(1);
         k++;
      end
      chk(nm, FW'(q_done[q]), FW'(1));
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while ((sb.size() != 0 || rq.size() != 0 || half) && k < 600) begin
         tick(1);
         k++;
      end
      tick(4);
      chk(nm, FW'(sb.size()), FW'(0));
   endtask

   task automatic clear_bench();
      sb.delete();
      rq.delete();
      half = 1'b0;
      mem_qr_valid = 1'b0;
   endtask

   task automatic run_q0(input string nm);
      req_log.delete();
      cfg(0, 19'h100, 19'h104, 16'd1);
      q_enable[0] = 1'b1;
      wait_done({nm, "_done"}, 0, 300);
      drain({nm, "_drain"});
      chk({nm, "_reads"}, FW'(req_log.size()), FW'(4));
      q_enable[0] = 1'b0;
      tick(2);
   endtask

   task automatic chk_outs_reset(input string nm);
      chk({nm, "_r_n"}, FW'(mem_r_n), FW'(1));
      chk({nm, "_ad"}, FW'(mem_ad_rd), FW'(0));
      chk({nm, "_wr_en"}, FW'(fifo_wr_en), FW'(0));
      chk({nm, "_data"}, fifo_data, FW'(0));
      chk({nm, "_qid"}, FW'(fifo_qid), FW'(0));
      chk({nm, "_done"}, FW'(q_done), FW'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t rows [4];
      int k, last_q0, first_q0, n_q2, pos;
      bit ok, q0_seen;

      rows[0] = '{0, 19'h100, 19'h104, 16'd1, 4};
      rows[1] = '{1, 19'h020, 19'h022, 16'd3, 6};
      rows[2] = '{3, 19'h040, 19'h040, 16'd1, 0};
      rows[3] = '{2, 19'h300, 19'h301, 16'd5, 5};

      rst_n = 1'b0;
      sw_rst = 1'b0;
      cal_done = 1'b1;
      mem_rd_full = 1'b0;
      fifo_prog_full = '0;
      q_enable = '0;
      q_addr_low = '0;
      q_addr_high = '0;
      q_replay_cnt = '0;
      tick(3);
      chk_outs_reset("reset");
      rst_n = 1'b1;
      tick(2);

      // stray beat with nothing in flight must be dropped
      stray = 1'b1;
      tick(4);
      chk("stray_no_word", FW'(wr_cyc.size()), FW'(0));

      for (int r = 0; r < 4; r++) begin
         req_log.delete();
         cfg(rows[r].q, rows[r].lo, rows[r].hi, rows[r].cnt);
         q_enable[rows[r].q] = 1'b1;
         wait_done($sformatf("row%0d_done", r), rows[r].q, 300);
         drain($sformatf("row%0d_drain", r));
         chk($sformatf("row%0d_reads", r), FW'(req_log.size()),
             FW'(rows[r].nrd));
         for (int j = 0; j < rows[r].nrd; j++)
            if (j < req_log.size())
               chk($sformatf("row%0d_addr%0d", r, j), FW'(req_log[j]),
                   FW'(rows[r].lo + AW'(j % int'(rows[r].hi - rows[r].lo))));
         q_enable[rows[r].q] = 1'b0;
         tick(2);
         chk($sformatf("row%0d_done_clr", r), FW'(q_done[rows[r].q]), FW'(0));
      end

      // two queues: strict alternation, per-queue address order
      req_log.delete();
      cfg(0, 19'h000, 19'h008, 16'd2);
      cfg(2, 19'h200, 19'h208, 16'd2);
      q_enable = 4'b0101;
      wait_done("alt_done0", 0, 500);
      wait_done("alt_done2", 2, 500);
      drain("alt_drain");
      chk("alt_reads", FW'(req_log.size()), FW'(32));
      ok = 1'b1;
      for (int j = 1; j < req_log.size(); j++)
         if (qid_of(req_log[j]) == qid_of(req_log[j-1])) ok = 1'b0;
      chk("alt_pattern", FW'(ok), FW'(1));
      ok = 1'b1;
      for (int j = 2; j < req_log.size(); j++)
         if (req_log[j][2:0] != req_log[j-2][2:0] + 3'd1) ok = 1'b0;
      chk("alt_addr_order", FW'(ok), FW'(1));
      q_enable = '0;
      tick(2);

      // prog_full stalls only its own queue
      cfg(0, 19'h000, 19'h008, 16'd0);
      cfg(2, 19'h200, 19'h208, 16'd0);
      req_log.delete();
      q_enable = 4'b0101;
      tick(10);
      fifo_prog_full[0] = 1'b1;
      tick(2);
      last_q0 = -1;
      for (int j = 0; j < req_log.size(); j++)
         if (qid_of(req_log[j]) == 0) last_q0 = int'(req_log[j]);
      req_log.delete();
      tick(30);
      q0_seen = 1'b0;
      n_q2 = 0;
      foreach (req_log[j]) begin
         if (qid_of(req_log[j]) == 0) q0_seen = 1'b1;
         else n_q2++;
      end
      chk("pf_no_q0", FW'(q0_seen), FW'(0));
      chk("pf_q2_runs", FW'(n_q2 > 5), FW'(1));
      req_log.delete();
      fifo_prog_full[0] = 1'b0;
      tick(10);
      first_q0 = -1;
      for (int j = req_log.size() - 1; j >= 0; j--)
         if (qid_of(req_log[j]) == 0) first_q0 = int'(req_log[j]);
      chk("pf_resume_addr", FW'(first_q0), FW'((last_q0 + 1) % 8));
      q_enable = '0;
      drain("pf_drain");

      // infinite replay: over 100 passes, never done
      cfg(1, 19'h020, 19'h022, 16'd0);
      req_log.delete();
      q_enable[1] = 1'b1;
      k = 0;
      while (req_log.size() < 202 && k < 2000) begin
         tick(1);
         k++;
      end
      chk("inf_passes", FW'(req_log.size() >= 202), FW'(1));
      chk("inf_not_done", FW'(q_done[1]), FW'(0));
      ok = 1'b1;
      foreach (req_log[j])
         if (req_log[j] != 19'h020 + AW'(j % 2)) ok = 1'b0;
      chk("inf_addr_seq", FW'(ok), FW'(1));
      q_enable[1] = 1'b0;
      drain("inf_drain");

      // 17th outstanding read waits for the first returned word
      mem_hold = 1'b1;
      req_log.delete();
      req_cyc.delete();
      wr_cyc.delete();
      q_enable[1] = 1'b1;
      tick(40);
      chk("os_cap16", FW'(req_log.size()), FW'(16));
      mem_hold = 1'b0;
      k = 0;
      while (req_log.size() < 17 && k < 100) begin
         tick(1);
         k++;
      end
      pos = (req_cyc.size() > 16) ? req_cyc[16] : 0;
      chk("os_17th_after_word",
          FW'(wr_cyc.size() > 0 && pos > wr_cyc[0]), FW'(1));
      q_enable[1] = 1'b0;
      drain("os_drain");

      // cal_done low, then mem_rd_full high: no requests
      cal_done = 1'b0;
      req_log.delete();
      cfg(0, 19'h100, 19'h104, 16'd1);
      q_enable[0] = 1'b1;
      tick(20);
      chk("cal_block", FW'(req_log.size()), FW'(0));
      cal_done = 1'b1;
      mem_rd_full = 1'b1;
      tick(20);
      chk("rdfull_block", FW'(req_log.size()), FW'(0));
      mem_rd_full = 1'b0;
      wait_done("gate_done", 0, 300);
      drain("gate_drain");
      chk("gate_reads", FW'(req_log.size()), FW'(4));
      q_enable[0] = 1'b0;
      tick(2);

      // async reset in the middle of a burst
      cfg(1, 19'h020, 19'h022, 16'd0);
      q_enable[1] = 1'b1;
      tick(15);
      rst_n = 1'b0;
      q_enable = '0;
      clear_bench();
      #1;
      chk_outs_reset("arst");
      tick(2);
      rst_n = 1'b1;
      tick(2);
      run_q0("post_arst");

      // soft reset in the middle of a burst
      q_enable[1] = 1'b1;
      tick(15);
      sw_rst = 1'b1;
      q_enable = '0;
      clear_bench();
      tick(1);
      chk_outs_reset("swrst");
      sw_rst = 1'b0;
      tick(2);
      run_q0("post_swrst");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
